// File: rtl/rgb2bayer.sv
// rgb2bayer: re-mosaics an RGB pixel stream into a Bayer raw stream; latency 2 cycles, no backpressure.
// Optional RGB2BAYER_RUNTIME_PAT_EN adds pat_sel, latched into the CFA phase on each vsync rising edge.
module rgb2bayer #(
   parameter int DATA_W  = 8,
   parameter int PATTERN = 0,
   parameter int IMG_W   = 640,
   parameter int IMG_H   = 480
) (
   input  logic              clk,
   input  logic              rst_n,
`ifdef RGB2BAYER_RUNTIME_PAT_EN
   input  logic [1:0]        pat_sel,
`endif
   input  logic              in_vsync,
   input  logic              in_href,
   input  logic [DATA_W-1:0] in_r,
   input  logic [DATA_W-1:0] in_g,
   input  logic [DATA_W-1:0] in_b,
   output logic              out_vsync,
   output logic              out_href,
   output logic [DATA_W-1:0] out_raw,
   output logic              line_err,
   output logic              frame_err
);

   localparam int             CW      = $clog2(IMG_W) + 1;
   localparam int             RW      = $clog2(IMG_H) + 1;
   localparam logic [CW-1:0]  COL_EXP = CW'(IMG_W);
   localparam logic [RW-1:0]  ROW_EXP = RW'(IMG_H);
   localparam logic [1:0]     PAT_RST = 2'(PATTERN);

   logic [CW-1:0]     col_q, col_d;
   logic [RW-1:0]     row_q, row_d;
   logic              href1_q, vsync1_q, er1_q, ec1_q;
   logic [DATA_W-1:0] r1_q, g1_q, b1_q;
   logic              href2_q, vsync2_q;
   logic [DATA_W-1:0] raw2_q, raw_d;
   logic              line_err_q, frame_err_q, seen_q;
   logic [1:0]        pat;
   logic              vs_rise, href_fall;

   // Stage-1 sync registers double as the previous-cycle samples for edge detection.
   assign vs_rise   = in_vsync & ~vsync1_q;
   assign href_fall = href1_q & ~in_href;

`ifdef RGB2BAYER_RUNTIME_PAT_EN
   logic [1:0] pat_q;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)       pat_q <= PAT_RST;
      else if (vs_rise) pat_q <= pat_sel;
   end
   assign pat = pat_q;
`else
   assign pat = PAT_RST;
`endif

   always_comb begin
      col_d = '0;
      if (in_href) col_d = (col_q == '1) ? col_q : col_q + CW'(1);
      // A vsync edge wins over a coincident href fall so the new frame starts on row 0.
      row_d = row_q;
      if (vs_rise)                        row_d = '0;
      else if (href_fall && row_q != '1)  row_d = row_q + RW'(1);
      case ({er1_q, ec1_q})
         2'b00:   raw_d = r1_q;
         2'b11:   raw_d = b1_q;
         default: raw_d = g1_q;
      endcase
      if (!href1_q) raw_d = '0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         col_q       <= '0;
         row_q       <= '0;
         href1_q     <= 1'b0;
         vsync1_q    <= 1'b0;
         er1_q       <= 1'b0;
         ec1_q       <= 1'b0;
         r1_q        <= '0;
         g1_q        <= '0;
         b1_q        <= '0;
         href2_q     <= 1'b0;
         vsync2_q    <= 1'b0;
         raw2_q      <= '0;
         line_err_q  <= 1'b0;
         frame_err_q <= 1'b0;
         seen_q      <= 1'b0;
      end else begin
         col_q    <= col_d;
         row_q    <= row_d;
         href1_q  <= in_href;
         vsync1_q <= in_vsync;
         er1_q    <= row_q[0] ^ pat[1];
         ec1_q    <= col_q[0] ^ pat[0];
         r1_q     <= in_r;
         g1_q     <= in_g;
         b1_q     <= in_b;
         href2_q  <= href1_q;
         vsync2_q <= vsync1_q;
         raw2_q   <= raw_d;
         if (href_fall && col_q != COL_EXP)          line_err_q  <= 1'b1;
         if (vs_rise && seen_q && row_q != ROW_EXP)  frame_err_q <= 1'b1;
         if (vs_rise)                                seen_q      <= 1'b1;
      end
   end

   assign out_vsync = vsync2_q;
   assign out_href  = href2_q;
   assign out_raw   = raw2_q;
   assign line_err  = line_err_q;
   assign frame_err = frame_err_q;

endmodule
